chop_sched: RTL and testbench

Segment sequencer for the chopper generator in the W7-X interlock datapath. Holds a small table of chop segments, each with its own change count, period length and period repeat count. On trigger it enables the chopper and drives `change_count`/`max_count` segment by segment, swapping values only on chop-period boundaries. It sits between the register bank/PCIe configuration path and the chopper generator.

---
 rtl/chop_sched.sv | 199 +++++++++++++++++++
 tb/tb_chop_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chop_sched.sv
// Segment sequencer for the chopper generator: validates a small table of
// (change_count, max_count, n_periods) segments and plays them back period by period.
module chop_sched #(
    parameter int N_SEG = 4,
    parameter int SEG_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_wr,
    input  logic [SEG_W-1:0] cfg_seg,
    input  logic [1:0]       cfg_sel,
    input  logic [31:0]      cfg_data,
    input  logic [SEG_W:0]   cfg_nseg,
    input  logic             arm_i,
    input  logic             trig_i,
    input  logic             abort_i,
    output logic             chop_en_o,
    output logic [31:0]      change_count_o,
    output logic [31:0]      max_count_o,
    output logic [SEG_W-1:0] seg_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             wr_rej_o
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ARMED, S_RUN} state_t;

    state_t state_q, state_d;

    logic [31:0]      cc_tab [N_SEG];
    logic [31:0]      mc_tab [N_SEG];
    logic [15:0]      np_tab [N_SEG];

    logic [SEG_W:0]   nseg_q, nseg_d;
    logic [SEG_W-1:0] chk_idx_q, chk_idx_d;
    logic [31:0]      pcnt_q, pcnt_d;
    logic [15:0]      rep_q, rep_d;
    logic             en_q, en_d;
    logic [31:0]      cc_q, cc_d;
    logic [31:0]      mc_q, mc_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             wr_rej_q, wr_rej_d;

    logic             wr_ok;
    logic             chk_ok, nseg_bad, last_chk;
    logic             pcnt_wrap, rep_wrap, seg_last;
    logic [SEG_W-1:0] nxt_seg;

    // Table has no reset so its contents survive rst_n.
    assign wr_ok = cfg_wr && (state_q == S_IDLE) && (cfg_sel != 2'd3);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            case (cfg_sel)
                2'd0:    cc_tab[cfg_seg] <= cfg_data;
                2'd1:    mc_tab[cfg_seg] <= cfg_data;
                default: np_tab[cfg_seg] <= cfg_data[15:0];
            endcase
        end
    end

    assign chk_ok   = (mc_tab[chk_idx_q] >= 32'd2) && (cc_tab[chk_idx_q] != 32'd0) &&
                      (cc_tab[chk_idx_q] < mc_tab[chk_idx_q]) && (np_tab[chk_idx_q] != 16'd0);
    assign nseg_bad = (nseg_q == '0) || (nseg_q > (SEG_W+1)'(N_SEG));
    assign last_chk = (({1'b0, chk_idx_q} + (SEG_W+1)'(1)) == nseg_q);

    assign pcnt_wrap = (pcnt_q == (mc_q - 32'd1));
    assign rep_wrap  = (rep_q == (np_tab[seg_q] - 16'd1));
    assign seg_last  = (({1'b0, seg_q} + (SEG_W+1)'(1)) == nseg_q);
    assign nxt_seg   = seg_q + SEG_W'(1);

    always_comb begin
        state_d   = state_q;
        nseg_d    = nseg_q;
        chk_idx_d = chk_idx_q;
        pcnt_d    = pcnt_q;
        rep_d     = rep_q;
        en_d      = en_q;
        cc_d      = cc_q;
        mc_d      = mc_q;
        seg_d     = seg_q;
        err_d     = err_q;
        done_d    = 1'b0;
        wr_rej_d  = cfg_wr && (state_q != S_IDLE) && (cfg_sel != 2'd3);

        case (state_q)
            S_IDLE: begin
                if (arm_i) begin
                    nseg_d    = cfg_nseg;
                    err_d     = 1'b0;
                    chk_idx_d = '0;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort_i || nseg_bad || !chk_ok) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (last_chk) begin
                    state_d = S_ARMED;
                end else begin
                    chk_idx_d = chk_idx_q + SEG_W'(1);
                end
            end
            S_ARMED: begin
                if (abort_i) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (trig_i) begin
                    cc_d    = cc_tab[0];
                    mc_d    = mc_tab[0];
                    seg_d   = '0;
                    en_d    = 1'b1;
                    pcnt_d  = '0;
                    rep_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (pcnt_wrap) begin
                    // Period boundary: new segment values apply from the next period.
                    pcnt_d = '0;
                    if (rep_wrap) begin
                        rep_d = '0;
                        if (seg_last) begin
                            en_d    = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            seg_d = nxt_seg;
                            cc_d  = cc_tab[nxt_seg];
                            mc_d  = mc_tab[nxt_seg];
                        end
                    end else begin
                        rep_d = rep_q + 16'd1;
                    end
                end else begin
                    pcnt_d = pcnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nseg_q    <= '0;
            chk_idx_q <= '0;
            pcnt_q    <= '0;
            rep_q     <= '0;
            en_q      <= 1'b0;
            cc_q      <= '0;
            mc_q      <= '0;
            seg_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_rej_q  <= 1'b0;
        end else begin
            nseg_q    <= nseg_d;
            chk_idx_q <= chk_idx_d;
            pcnt_q    <= pcnt_d;
            rep_q     <= rep_d;
            en_q      <= en_d;
            cc_q      <= cc_d;
            mc_q      <= mc_d;
            seg_q     <= seg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wr_rej_q  <= wr_rej_d;
        end
    end

    assign chop_en_o      = en_q;
    assign change_count_o = cc_q;
    assign max_count_o    = mc_q;
    assign seg_o          = seg_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign wr_rej_o       = wr_rej_q;

endmodule

// File: tb/tb_chop_sched.sv
// Self-checking bench for chop_sched: per-cycle expected outputs are queued
// from a segment-duration model at trigger time and popped as the run plays out.
module tb_chop_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_seg = '0;
    logic [1:0]  cfg_sel = '0;
    logic [31:0] cfg_data = '0;
    logic [2:0]  cfg_nseg = '0;
    logic        arm_i = 1'b0, trig_i = 1'b0, abort_i = 1'b0;
    logic        chop_en_o, busy_o, done_o, err_o, wr_rej_o;
    logic [31:0] change_count_o, max_count_o;
    logic [1:0]  seg_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        en;
        logic [31:0] cc;
        logic [31:0] mc;
        logic [1:0]  seg;
        logic        done;
    } exp_t;

    exp_t sb[$];

    logic [31:0] tcc [4];
    logic [31:0] tmc [4];
    logic [15:0] tnp [4];

    chop_sched #(.N_SEG(4), .SEG_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_seg(cfg_seg), .cfg_sel(cfg_sel),
        .cfg_data(cfg_data), .cfg_nseg(cfg_nseg), .arm_i(arm_i), .trig_i(trig_i),
        .abort_i(abort_i), .chop_en_o(chop_en_o), .change_count_o(change_count_o),
        .max_count_o(max_count_o), .seg_o(seg_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .wr_rej_o(wr_rej_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_field(input int seg, input int sel, input logic [31:0] data);
        cfg_wr = 1'b1; cfg_seg = 2'(seg); cfg_sel = 2'(sel); cfg_data = data;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic write_seg(input int seg, input int cc, input int mc, input int np);
        write_field(seg, 0, 32'(cc));
        write_field(seg, 1, 32'(mc));
        write_field(seg, 2, 32'(np));
        tcc[seg] = 32'(cc); tmc[seg] = 32'(mc); tnp[seg] = 16'(np);
    endtask

    // Arm with a valid table: arm edge plus n CHECK cycles leaves the DUT ARMED.
    task automatic do_arm(input int n);
        cfg_nseg = 3'(n);
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        repeat (n) tick();
        total++;
        if ({busy_o, err_o, chop_en_o} !== 3'b100) begin
            bad++;
            $display("FAIL arm_ok: got busy/err/en=%b want 100", {busy_o, err_o, chop_en_o});
        end
    endtask

    task automatic build_exp(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < int'(tmc[k]) * int'(tnp[k]); j++) begin
                e.en = 1'b1; e.cc = tcc[k]; e.mc = tmc[k]; e.seg = 2'(k); e.done = 1'b0;
                sb.push_back(e);
            end
        end
        e.en = 1'b0; e.cc = tcc[n-1]; e.mc = tmc[n-1]; e.seg = 2'(n-1); e.done = 1'b1;
        sb.push_back(e);
    endtask

    // Trigger, then compare every cycle until the queue drains; optional write at cycle wr_at.
    task automatic run_sb(input string name, input int wr_at);
        exp_t e;
        int   i = 0;
        trig_i = 1'b1;
        while (sb.size() > 0) begin
            if (i == wr_at) begin
                cfg_wr = 1'b1; cfg_seg = 2'd0; cfg_sel = 2'd0; cfg_data = 32'd1;
            end
            tick();
            trig_i = 1'b0;
            cfg_wr = 1'b0;
            e = sb.pop_front();
            total++;
            if ({chop_en_o, change_count_o, max_count_o, seg_o, done_o} !== {e.en, e.cc, e.mc, e.seg, e.done}) begin
                bad++;
                $display("FAIL %s cyc%0d: got en=%b cc=%0d mc=%0d seg=%0d done=%b want en=%b cc=%0d mc=%0d seg=%0d done=%b",
                         name, i, chop_en_o, change_count_o, max_count_o, seg_o, done_o,
                         e.en, e.cc, e.mc, e.seg, e.done);
            end
            if (i == wr_at) begin
                total++;
                if (wr_rej_o !== 1'b1) begin
                    bad++;
                    $display("FAIL wr_rej: got %b want 1", wr_rej_o);
                end
            end
            i++;
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++;
        if ({chop_en_o, change_count_o, max_count_o, seg_o, busy_o, done_o, err_o, wr_rej_o} !== '0) begin
            bad++;
            $display("FAIL reset: got en=%b cc=%0d mc=%0d seg=%0d busy=%b done=%b err=%b rej=%b want all 0",
                     chop_en_o, change_count_o, max_count_o, seg_o, busy_o, done_o, err_o, wr_rej_o);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        write_seg(0, 3, 8, 2);
        do_arm(1);
        build_exp(1);
        run_sb("single", -1);
        tick();
        total++;
        if ({done_o, busy_o, change_count_o, max_count_o} !== {1'b0, 1'b0, 32'd3, 32'd8}) begin
            bad++;
            $display("FAIL single_hold: got done=%b busy=%b cc=%0d mc=%0d want 0 0 3 8",
                     done_o, busy_o, change_count_o, max_count_o);
        end
    endtask

    task automatic test_three_seg();
        write_seg(0, 2, 4, 1);
        write_seg(1, 5, 10, 2);
        write_seg(2, 1, 6, 3);
        do_arm(3);
        build_exp(3);
        run_sb("three_seg", -1);
    endtask

    task automatic test_validation();
        write_seg(1, 10, 10, 2);
        cfg_nseg = 3'd2;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        tick();
        total++;
        if ({busy_o, err_o} !== 2'b10) begin
            bad++;
            $display("FAIL val_mid: got busy/err=%b want 10", {busy_o, err_o});
        end
        tick();
        total++;
        if ({busy_o, err_o} !== 2'b01) begin
            bad++;
            $display("FAIL val_err: got busy/err=%b want 01", {busy_o, err_o});
        end
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        total++;
        if ({chop_en_o, busy_o, err_o} !== 3'b001) begin
            bad++;
            $display("FAIL val_trig: got en/busy/err=%b want 001", {chop_en_o, busy_o, err_o});
        end
        // nseg 0 fails on the first CHECK cycle; the arm itself clears err first.
        cfg_nseg = 3'd0;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        total++;
        if ({busy_o, err_o} !== 2'b10) begin
            bad++;
            $display("FAIL nseg0_clr: got busy/err=%b want 10", {busy_o, err_o});
        end
        tick();
        total++;
        if ({busy_o, err_o} !== 2'b01) begin
            bad++;
            $display("FAIL nseg0_err: got busy/err=%b want 01", {busy_o, err_o});
        end
        cfg_nseg = 3'd5;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        tick();
        total++;
        if ({busy_o, err_o} !== 2'b01) begin
            bad++;
            $display("FAIL nseg5_err: got busy/err=%b want 01", {busy_o, err_o});
        end
        write_seg(1, 5, 10, 2);
    endtask

    task automatic test_abort_boundary();
        do_arm(3);
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        repeat (3) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        total++;
        if ({chop_en_o, err_o, busy_o, done_o, seg_o, change_count_o, max_count_o} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd2, 32'd4}) begin
            bad++;
            $display("FAIL abort: got en=%b err=%b busy=%b done=%b seg=%0d cc=%0d mc=%0d want 0 1 0 0 0 2 4",
                     chop_en_o, err_o, busy_o, done_o, seg_o, change_count_o, max_count_o);
        end
        tick();
        total++;
        if ({done_o, chop_en_o} !== 2'b00) begin
            bad++;
            $display("FAIL abort_nodone: got done/en=%b want 00", {done_o, chop_en_o});
        end
    endtask

    task automatic test_rejected_write();
        do_arm(3);
        build_exp(3);
        run_sb("rej_run", 5);
        do_arm(3);
        build_exp(3);
        run_sb("rej_rerun", -1);
    endtask

    task automatic test_reset_midrun();
        do_arm(3);
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        total++;
        if ({chop_en_o, change_count_o, max_count_o, seg_o, busy_o, done_o, err_o, wr_rej_o} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got en=%b cc=%0d mc=%0d seg=%0d busy=%b done=%b err=%b want all 0",
                     chop_en_o, change_count_o, max_count_o, seg_o, busy_o, done_o, err_o);
        end
        rst_n = 1'b1;
        tick();
        do_arm(3);
        build_exp(3);
        run_sb("reset_rerun", -1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_three_seg();
        test_validation();
        test_abort_boundary();
        test_rejected_write();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
